// File: rtl/vx_opc_dispatch.sv
// Operand-collector allocator for one issue slice: picks a free collector per
// instruction, tracks relative age of in-flight entries and exports wait masks.
module vx_opc_dispatch #(
  parameter int unsigned NUM_OPCS     = 4,
  parameter int unsigned NUM_VOPCS    = 1,
  parameter int unsigned NUM_WIS      = 4,
  parameter int unsigned ORDER_MODE   = 0,
  parameter int unsigned SCALAR_SPILL = 0,
  parameter int unsigned CTR_W        = 16,
  localparam int unsigned WIS_W = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1,
  localparam int unsigned OPC_W = (NUM_OPCS > 1) ? $clog2(NUM_OPCS) : 1,
  localparam int unsigned OCC_W = $clog2(NUM_OPCS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enq_valid,
  input  logic                         enq_is_vec,
  input  logic [WIS_W-1:0]             enq_wis,
  output logic                         enq_ready,
  output logic [OPC_W-1:0]             enq_opc,
  input  logic                         deq_valid,
  input  logic [OPC_W-1:0]             deq_opc,
  input  logic                         deq_eop,
  output logic [NUM_OPCS-1:0]          opc_busy,
  output logic [NUM_OPCS*NUM_OPCS-1:0] opc_wait_mask,
  output logic [OCC_W-1:0]             occupancy,
  output logic [CTR_W-1:0]             perf_stalls,
  output logic                         err_deq
);

  // Collectors [0, NUM_VOPCS) can hold vector instructions.
  localparam logic [NUM_OPCS-1:0] VEC_MASK  = NUM_OPCS'((64'(1) << NUM_VOPCS) - 64'(1));
  localparam logic [NUM_OPCS-1:0] SCAL_MASK = ~VEC_MASK;

  logic [NUM_OPCS-1:0] busy_q, busy_d;
  logic [NUM_OPCS-1:0] older_q [NUM_OPCS];
  logic [NUM_OPCS-1:0] older_d [NUM_OPCS];
  logic [WIS_W-1:0]    wis_q   [NUM_OPCS];
  logic [WIS_W-1:0]    wis_d   [NUM_OPCS];
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [CTR_W-1:0]    stall_q, stall_d;
  logic                err_q, err_d;

  logic [NUM_OPCS-1:0] free_vec, free_scal, cand;
  logic [NUM_OPCS-1:0] deq_hit, free_now, alloc_oh;
  logic                alloc, deq_idle;

  // Lowest free eligible collector; scalars fall back to vector slots only when spilling.
  always_comb begin
    free_vec  = ~busy_q & VEC_MASK;
    free_scal = ~busy_q & SCAL_MASK;
    if (enq_is_vec) begin
      cand = free_vec;
    end else if ((free_scal != '0) || (SCALAR_SPILL == 0)) begin
      cand = free_scal;
    end else begin
      cand = free_vec;
    end
    enq_opc = '0;
    for (int i = NUM_OPCS - 1; i >= 0; i--) begin
      if (cand[i]) enq_opc = OPC_W'(i);
    end
    enq_ready = |cand;
  end

  // Decode dequeue and allocation into one-hot collector vectors.
  always_comb begin
    alloc = enq_valid && enq_ready;
    for (int j = 0; j < NUM_OPCS; j++) begin
      deq_hit[j]  = deq_valid && (deq_opc == OPC_W'(j));
      alloc_oh[j] = alloc && (enq_opc == OPC_W'(j));
    end
    free_now = deq_hit & busy_q & {NUM_OPCS{deq_eop}};
    deq_idle = deq_valid && ((deq_hit & busy_q) == '0);
  end

  // Next-state for busy, age matrix, warp tags and status counters.
  always_comb begin
    busy_d = (busy_q & ~free_now) | alloc_oh;
    for (int i = 0; i < NUM_OPCS; i++) begin
      older_d[i] = older_q[i] & ~free_now & ~alloc_oh;
      if (free_now[i]) older_d[i] = '0;
      // A collector freed this cycle is not counted as older than the new entry.
      if (alloc_oh[i]) older_d[i] = busy_q & ~free_now;
      wis_d[i] = alloc_oh[i] ? enq_wis : wis_q[i];
    end
    occ_d = '0;
    for (int i = 0; i < NUM_OPCS; i++) begin
      occ_d = occ_d + OCC_W'(busy_d[i]);
    end
    stall_d = stall_q;
    if (enq_valid && !enq_ready && (stall_q != {CTR_W{1'b1}})) begin
      stall_d = stall_q + CTR_W'(1);
    end
    err_d = err_q | deq_idle;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= '0;
      occ_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_OPCS; i++) begin
        older_q[i] <= '0;
        wis_q[i]   <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_OPCS; i++) begin
        older_q[i] <= older_d[i];
        wis_q[i]   <= wis_d[i];
      end
    end
  end

  // Wait mask from registered state only: older busy entries of the same warp (or any, in global mode).
  always_comb begin
    opc_wait_mask = '0;
    for (int i = 0; i < NUM_OPCS; i++) begin
      for (int j = 0; j < NUM_OPCS; j++) begin
        opc_wait_mask[i*NUM_OPCS + j] = (i != j) && busy_q[i] && busy_q[j] && older_q[i][j] &&
                                        ((ORDER_MODE != 0) || (wis_q[i] == wis_q[j]));
      end
    end
  end

  assign opc_busy    = busy_q;
  assign occupancy   = occ_q;
  assign perf_stalls = stall_q;
  assign err_deq     = err_q;

endmodule

// File: tb/tb_vx_opc_dispatch.sv
// Directed bench for vx_opc_dispatch: four instances (default, global order,
// scalar spill, narrow stall counter) share one stimulus stream.
module tb_vx_opc_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_valid, enq_is_vec;
  logic [1:0]  enq_wis;
  logic        deq_valid, deq_eop;
  logic [1:0]  deq_opc;

  logic        ready [4];
  logic [1:0]  opc   [4];
  logic [3:0]  busy  [4];
  logic [15:0] mask  [4];
  logic [2:0]  occ   [4];
  logic [15:0] stalls [3];
  logic [1:0]  stalls_n;
  logic        err   [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_opc_dispatch u_dut0 (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_is_vec(enq_is_vec), .enq_wis(enq_wis),
    .enq_ready(ready[0]), .enq_opc(opc[0]), .deq_valid(deq_valid), .deq_opc(deq_opc), .deq_eop(deq_eop),
    .opc_busy(busy[0]), .opc_wait_mask(mask[0]), .occupancy(occ[0]), .perf_stalls(stalls[0]), .err_deq(err[0]));

  vx_opc_dispatch #(.ORDER_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_is_vec(enq_is_vec), .enq_wis(enq_wis),
    .enq_ready(ready[1]), .enq_opc(opc[1]), .deq_valid(deq_valid), .deq_opc(deq_opc), .deq_eop(deq_eop),
    .opc_busy(busy[1]), .opc_wait_mask(mask[1]), .occupancy(occ[1]), .perf_stalls(stalls[1]), .err_deq(err[1]));

  vx_opc_dispatch #(.SCALAR_SPILL(1)) u_dut2 (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_is_vec(enq_is_vec), .enq_wis(enq_wis),
    .enq_ready(ready[2]), .enq_opc(opc[2]), .deq_valid(deq_valid), .deq_opc(deq_opc), .deq_eop(deq_eop),
    .opc_busy(busy[2]), .opc_wait_mask(mask[2]), .occupancy(occ[2]), .perf_stalls(stalls[2]), .err_deq(err[2]));

  vx_opc_dispatch #(.CTR_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_is_vec(enq_is_vec), .enq_wis(enq_wis),
    .enq_ready(ready[3]), .enq_opc(opc[3]), .deq_valid(deq_valid), .deq_opc(deq_opc), .deq_eop(deq_eop),
    .opc_busy(busy[3]), .opc_wait_mask(mask[3]), .occupancy(occ[3]), .perf_stalls(stalls_n), .err_deq(err[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one instruction for a cycle, checking the grant on the default instance.
  task automatic enq(input logic vec, input logic [1:0] wis, input logic [1:0] exp_opc, input string tag);
    enq_valid  = 1'b1;
    enq_is_vec = vec;
    enq_wis    = wis;
    #1;
    check({tag, "_ready"}, 32'(ready[0]), 32'd1);
    check({tag, "_opc"}, 32'(opc[0]), 32'(exp_opc));
    @(posedge clk); #1;
    enq_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enq_valid = 1'b0; enq_is_vec = 1'b0; enq_wis = 2'd0;
    deq_valid = 1'b0; deq_opc = 2'd0; deq_eop = 1'b0;
    #12 reset = 1'b1;
    @(posedge clk); #1;

    check("rst_busy", 32'(busy[0]), 32'h0);
    check("rst_occ", 32'(occ[0]), 32'h0);
    check("rst_stalls", 32'(stalls[0]), 32'h0);
    check("rst_err", 32'(err[0]), 32'h0);
    check("rst_mask", 32'(mask[0]), 32'h0);

    // Mixed scalar/vector allocation on one warp.
    enq(1'b0, 2'd2, 2'd1, "s1_a");
    enq(1'b1, 2'd2, 2'd0, "s1_b");
    enq(1'b0, 2'd2, 2'd2, "s1_c");
    check("s1_busy", 32'(busy[0]), 32'h7);
    check("s1_occ", 32'(occ[0]), 32'd3);
    check("s1_mask", 32'(mask[0]), 32'h0302);
    check("s1_mask_glob", 32'(mask[1]), 32'h0302);

    // Dequeue of an idle collector, then a non-final packet.
    deq_valid = 1'b1; deq_eop = 1'b1; deq_opc = 2'd3;
    @(posedge clk); #1;
    deq_valid = 1'b0;
    check("idle_err", 32'(err[0]), 32'd1);
    check("idle_busy", 32'(busy[0]), 32'h7);
    deq_valid = 1'b1; deq_eop = 1'b0; deq_opc = 2'd1;
    @(posedge clk); #1;
    deq_valid = 1'b0;
    check("noeop_busy", 32'(busy[0]), 32'h7);
    check("noeop_occ", 32'(occ[0]), 32'd3);

    // Asynchronous reset mid-cycle.
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy[0]), 32'h0);
    check("arst_occ", 32'(occ[0]), 32'h0);
    check("arst_err", 32'(err[0]), 32'h0);
    check("arst_mask", 32'(mask[0]), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Different warps: per-warp mode ignores, global mode orders.
    enq(1'b0, 2'd0, 2'd1, "s2_a");
    enq(1'b0, 2'd1, 2'd2, "s2_b");
    check("s2_mask_warp", 32'(mask[0]), 32'h0);
    check("s2_mask_glob", 32'(mask[1]), 32'h0200);
    pulse_reset();

    // Scalar collectors full: stalls without spill, spill grants collector 0.
    enq(1'b0, 2'd0, 2'd1, "s3_a");
    enq(1'b0, 2'd0, 2'd2, "s3_b");
    enq(1'b0, 2'd0, 2'd3, "s3_c");
    check("s3_busy", 32'(busy[0]), 32'he);
    enq_valid = 1'b1; enq_is_vec = 1'b0; enq_wis = 2'd0;
    #1;
    check("s3_spill_ready", 32'(ready[2]), 32'd1);
    check("s3_spill_opc", 32'(opc[2]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("s3_stall_ready", 32'(ready[0]), 32'd0);
      check("s3_stall_opc", 32'(opc[0]), 32'd0);
      @(posedge clk); #1;
    end
    enq_valid = 1'b0;
    check("s3_stalls", 32'(stalls[0]), 32'd5);
    check("s3_stalls_sat", 32'(stalls_n), 32'd3);
    check("s3_busy_hold", 32'(busy[0]), 32'he);
    check("s3_spill_stalls", 32'(stalls[2]), 32'd4);
    check("s3_spill_busy", 32'(busy[2]), 32'hf);

    // Full, then free collector 2 while offering: not reusable that cycle.
    enq(1'b1, 2'd0, 2'd0, "s4_vec");
    enq_valid = 1'b1; enq_is_vec = 1'b0; enq_wis = 2'd0;
    deq_valid = 1'b1; deq_eop = 1'b1; deq_opc = 2'd2;
    #1;
    check("s4_full_ready", 32'(ready[0]), 32'd0);
    check("s4_full_opc", 32'(opc[0]), 32'd0);
    @(posedge clk); #1;
    enq_valid = 1'b0; deq_valid = 1'b0;
    check("s4_freed_busy", 32'(busy[0]), 32'hb);
    enq(1'b0, 2'd0, 2'd2, "s4_realloc");
    check("s4_mask", 32'(mask[0]), 32'h2b0a);
    check("s4_stalls", 32'(stalls[0]), 32'd6);
    check("s4_stalls_sat", 32'(stalls_n), 32'd3);
    check("s4_err", 32'(err[0]), 32'd0);
    pulse_reset();

    // Vector collector busy: vector stalls though scalar slots are free.
    enq(1'b1, 2'd0, 2'd0, "s5_vec");
    enq_valid = 1'b1; enq_is_vec = 1'b1;
    #1;
    check("s5_ready", 32'(ready[0]), 32'd0);
    check("s5_opc", 32'(opc[0]), 32'd0);
    @(posedge clk); #1;
    enq_valid = 1'b0;
    check("s5_busy", 32'(busy[0]), 32'h1);
    check("s5_occ", 32'(occ[0]), 32'd1);
    check("s5_stalls", 32'(stalls[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
